ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 203 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU and address generation, plus an iterative
// 16-step shift-add multiplier and restoring divider that stall the upstream stage.
module ex_stage #(
    parameter int          DATA_W = 16,
    parameter logic [15:0] DIV0_Q = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        opcode_in,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [DATA_W-1:0] imedi_in,
    input  logic [3:0]        destreg_in,
    input  logic              set_regwrite_in,
    input  logic              set_memwrite_in,
    output logic              stall_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] result_out,
    output logic [DATA_W-1:0] addr_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic [3:0]        destreg_out,
    output logic              set_regwrite_out,
    output logic              set_memwrite_out,
    output logic              set_memread_out,
    output logic [1:0]        flags_out
);

    localparam logic [7:0] OP_LW  = 8'hC1;
    localparam logic [7:0] OP_LW1 = 8'hA1;
    localparam logic [7:0] OP_SW  = 8'hC2;
    localparam logic [7:0] OP_ADD = 8'h43;
    localparam logic [7:0] OP_SUB = 8'h44;
    localparam logic [7:0] OP_MUL = 8'h45;
    localparam logic [7:0] OP_DIV = 8'h46;
    localparam logic [7:0] OP_AND = 8'h47;
    localparam logic [7:0] OP_OR  = 8'h48;
    localparam logic [7:0] OP_CMP = 8'h49;
    localparam logic [7:0] OP_NOT = 8'h2A;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e      state, next_state;
    logic [3:0]  iter_cnt;
    logic        is_div;
    logic [15:0] work_a;     // multiplicand (MUL) or dividend shifting into quotient (DIV)
    logic [15:0] work_b;     // multiplier (MUL) or divisor (DIV)
    logic [15:0] acc;        // partial product (MUL) or partial remainder (DIV)
    logic [3:0]  mc_dest;
    logic        mc_regwrite;
    logic        mc_memwrite;

    logic        single_op;
    logic        mem_op;
    logic        start_mc;
    logic        mc_done;
    logic [15:0] alu_result;
    logic [15:0] mem_addr;
    logic [15:0] mul_next;
    logic [16:0] div_shift;
    logic        div_ge;
    logic [15:0] div_rem_next;
    logic [15:0] quo_next;
    logic [15:0] mc_result;

    // Decode and single-cycle datapath.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        single_op  = 1'b0;
        mem_op     = 1'b0;
        alu_result = '0;
        mem_addr   = '0;
        case (opcode_in)
            OP_ADD: begin single_op = 1'b1; alu_result = a_in + b_in; end
            OP_SUB: begin single_op = 1'b1; alu_result = a_in - b_in; end
            OP_AND: begin single_op = 1'b1; alu_result = a_in & b_in; end
            OP_OR:  begin single_op = 1'b1; alu_result = a_in | b_in; end
            OP_NOT: begin single_op = 1'b1; alu_result = ~a_in; end
            OP_CMP: begin
                single_op = 1'b1;
                if (a_in == b_in)     alu_result = 16'h0000;
                else if (a_in > b_in) alu_result = 16'h0001;
                else                  alu_result = 16'hFFFF;
            end
            OP_LW:  begin mem_op = 1'b1; mem_addr = imedi_in + b_in; end
            OP_LW1: begin mem_op = 1'b1; mem_addr = imedi_in; end
            OP_SW:  begin mem_op = 1'b1; mem_addr = imedi_in + b_in; end
            default: ;
        endcase
    end

    assign start_mc = (state == IDLE) && in_valid &&
                      ((opcode_in == OP_MUL) || (opcode_in == OP_DIV));
    assign mc_done  = (state == BUSY) && (iter_cnt == 4'd15);

    // One iteration step of each multi-cycle unit.
    always_comb begin
        mul_next     = acc + (work_b[0] ? work_a : 16'h0000);
        div_shift    = {acc, work_a[15]};
        div_ge       = div_shift >= {1'b0, work_b};
        div_rem_next = div_ge ? (div_shift[15:0] - work_b) : div_shift[15:0];
        quo_next     = {work_a[14:0], div_ge};
        if (is_div) mc_result = (work_b == 16'h0000) ? DIV0_Q : quo_next;
        else        mc_result = mul_next;
    end

    // FSM: state register.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // FSM: next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start_mc) next_state = BUSY;
            BUSY: if (mc_done)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM: output logic.
    always_comb begin
        stall_out = (state == BUSY);
    end

    // Datapath and EX/MEM register.
    // NOTE: every register here is reset, including the iteration working set, so an aborted divide leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!reset) begin
            iter_cnt         <= '0;
            is_div           <= 1'b0;
            work_a           <= '0;
            work_b           <= '0;
            acc              <= '0;
            mc_dest          <= '0;
            mc_regwrite      <= 1'b0;
            mc_memwrite      <= 1'b0;
            valid_out        <= 1'b0;
            result_out       <= '0;
            addr_out         <= '0;
            store_data_out   <= '0;
            destreg_out      <= '0;
            set_regwrite_out <= 1'b0;
            set_memwrite_out <= 1'b0;
            set_memread_out  <= 1'b0;
            flags_out        <= 2'b00;
        end else begin
            valid_out        <= 1'b0;
            result_out       <= '0;
            addr_out         <= '0;
            store_data_out   <= '0;
            destreg_out      <= '0;
            set_regwrite_out <= 1'b0;
            set_memwrite_out <= 1'b0;
            set_memread_out  <= 1'b0;
            if (state == IDLE) begin
                if (in_valid && (single_op || mem_op)) begin
                    valid_out        <= 1'b1;
                    result_out       <= alu_result;
                    addr_out         <= mem_addr;
                    store_data_out   <= (opcode_in == OP_SW) ? a_in : 16'h0000;
                    destreg_out      <= destreg_in;
                    set_regwrite_out <= set_regwrite_in;
                    set_memwrite_out <= set_memwrite_in;
                    set_memread_out  <= (opcode_in == OP_LW) || (opcode_in == OP_LW1);
                    if (opcode_in == OP_CMP) flags_out <= {a_in < b_in, a_in == b_in};
                end else if (start_mc) begin
                    iter_cnt    <= '0;
                    is_div      <= (opcode_in == OP_DIV);
                    work_a      <= a_in;
                    work_b      <= b_in;
                    acc         <= '0;
                    mc_dest     <= destreg_in;
                    mc_regwrite <= set_regwrite_in;
                    mc_memwrite <= set_memwrite_in;
                end
            end else begin
                if (is_div) begin
                    acc    <= div_rem_next;
                    work_a <= quo_next;
                end else begin
                    acc    <= mul_next;
                    work_a <= {work_a[14:0], 1'b0};
                    work_b <= {1'b0, work_b[15:1]};
                end
                if (mc_done) begin
                    iter_cnt         <= '0;
                    valid_out        <= 1'b1;
                    result_out       <= mc_result;
                    destreg_out      <= mc_dest;
                    set_regwrite_out <= mc_regwrite;
                    set_memwrite_out <= mc_memwrite;
                end else begin
                    iter_cnt <= iter_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus randomized single-cycle and
// multi-cycle traffic against an arithmetic reference model.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  opcode_in;
    logic [15:0] a_in, b_in, imedi_in;
    logic [3:0]  destreg_in;
    logic        set_regwrite_in, set_memwrite_in;
    logic        stall_out, valid_out;
    logic [15:0] result_out, addr_out, store_data_out;
    logic [3:0]  destreg_out;
    logic        set_regwrite_out, set_memwrite_out, set_memread_out;
    logic [1:0]  flags_out;

    typedef struct packed {
        logic        valid;
        logic [15:0] result;
        logic [15:0] addr;
        logic [15:0] store;
        logic [3:0]  dest;
        logic        rw;
        logic        mw;
        logic        mr;
        logic [1:0]  flags;
    } out_t;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    logic [1:0] flags_m;

    ex_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .opcode_in(opcode_in),
        .a_in(a_in), .b_in(b_in), .imedi_in(imedi_in), .destreg_in(destreg_in),
        .set_regwrite_in(set_regwrite_in), .set_memwrite_in(set_memwrite_in),
        .stall_out(stall_out), .valid_out(valid_out), .result_out(result_out),
        .addr_out(addr_out), .store_data_out(store_data_out), .destreg_out(destreg_out),
        .set_regwrite_out(set_regwrite_out), .set_memwrite_out(set_memwrite_out),
        .set_memread_out(set_memread_out), .flags_out(flags_out)
    );

    always #5 clk = ~clk;

    function automatic out_t get_obs();
        out_t o;
        o = '{valid_out, result_out, addr_out, store_data_out, destreg_out,
              set_regwrite_out, set_memwrite_out, set_memread_out, flags_out};
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic v, input logic [7:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] imm,
                         input logic [3:0] dest, input logic rw, input logic mw);
        in_valid = v; opcode_in = op; a_in = a; b_in = b; imedi_in = imm;
        destreg_in = dest; set_regwrite_in = rw; set_memwrite_in = mw;
    endtask

    // Expected registered outputs for one IDLE-cycle instruction, with a mask of the bits that matter.
    task automatic model_single(input logic v, input logic [7:0] op, input logic [15:0] a,
                                input logic [15:0] b, input logic [15:0] imm,
                                input logic [3:0] dest, input logic rw, input logic mw,
                                output out_t e, output out_t m);
        bit alu, mem;
        e = '0;
        m = '1;
        alu = v && (op inside {8'h43, 8'h44, 8'h47, 8'h48, 8'h49, 8'h2A});
        mem = v && (op inside {8'hC1, 8'hA1, 8'hC2});
        if (alu || mem) begin
            e.valid = 1'b1; e.dest = dest; e.rw = rw; e.mw = mw;
        end
        case (op)
            8'h43: e.result = a + b;
            8'h44: e.result = a - b;
            8'h47: e.result = a & b;
            8'h48: e.result = a | b;
            8'h2A: e.result = ~a;
            8'h49: e.result = (a == b) ? 16'h0000 : ((a > b) ? 16'h0001 : 16'hFFFF);
            default: e.result = 16'h0000;
        endcase
        if (mem) begin
            e.addr = (op == 8'hA1) ? imm : imm + b;
            e.store = (op == 8'hC2) ? a : 16'h0000;
            e.mr = (op != 8'hC2);
            m.result = '0;
        end
        if (!alu && !mem) begin
            m.result = '0; m.addr = '0; m.store = '0; m.dest = '0;
        end
        if (alu && op == 8'h49) flags_m = {a < b, a == b};
        e.flags = flags_m;
    endtask

    task automatic do_single(input string name, input logic v, input logic [7:0] op,
                             input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm,
                             input logic [3:0] dest, input logic rw, input logic mw);
        out_t e, m, o;
        apply(v, op, a, b, imm, dest, rw, mw);
        model_single(v, op, a, b, imm, dest, rw, mw, e, m);
        step();
        o = get_obs();
        total_cnt++;
        if (((o & m) !== (e & m)) || stall_out !== 1'b0)
            $display("FAIL %s op=%h: got %h stall=%b, want %h (mask %h) stall=0",
                     name, op, o, stall_out, e, m);
        else pass_cnt++;
    endtask

    // Runs one MUL/DIV from its accept edge through the completion edge.
    task automatic run_mc(input string name, input logic [7:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] dest, input logic rw);
        out_t e, o;
        logic [31:0] prod;
        prod = a * b;
        e = '0;
        e.valid = 1'b1;
        e.result = (op == 8'h45) ? prod[15:0] : ((b == 16'h0) ? 16'hFFFF : a / b);
        e.dest = dest; e.rw = rw; e.flags = flags_m;
        apply(1'b1, op, a, b, 16'h0, dest, rw, 1'b0);
        step();
        total_cnt++;
        if (stall_out !== 1'b1 || valid_out !== 1'b0)
            $display("FAIL %s accept: stall=%b valid=%b, want stall=1 valid=0", name, stall_out, valid_out);
        else pass_cnt++;
        for (int k = 1; k <= 15; k++) begin
            apply(1'($urandom_range(0, 1)), 8'h43, 16'($urandom), 16'($urandom), 16'($urandom),
                  4'($urandom), 1'b1, 1'b1);
            step();
            total_cnt++;
            if (stall_out !== 1'b1 || valid_out !== 1'b0 || set_memwrite_out !== 1'b0)
                $display("FAIL %s busy cycle %0d: stall=%b valid=%b mw=%b, want 1 0 0",
                         name, k, stall_out, valid_out, set_memwrite_out);
            else pass_cnt++;
        end
        step();
        o = get_obs();
        total_cnt++;
        if (o !== e || stall_out !== 1'b0)
            $display("FAIL %s done: got %h stall=%b, want %h stall=0", name, o, stall_out, e);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        apply(1'b1, 8'h43, 16'h1111, 16'h2222, 16'h0, 4'h5, 1'b1, 1'b1);
        step();
        step();
        flags_m = 2'b00;
        total_cnt++;
        if (get_obs() !== out_t'('0) || stall_out !== 1'b0)
            $display("FAIL reset_state: got %h stall=%b, want 0 stall=0", get_obs(), stall_out);
        else pass_cnt++;
        reset = 1'b1;
    endtask

    task automatic test_add();
        do_single("add_0005_0003", 1'b1, 8'h43, 16'h0005, 16'h0003, 16'h0, 4'h2, 1'b1, 1'b0);
        total_cnt++;
        if (result_out !== 16'h0008 || destreg_out !== 4'h2 || valid_out !== 1'b1)
            $display("FAIL add_literal: result=%h dest=%h valid=%b, want 0008 2 1",
                     result_out, destreg_out, valid_out);
        else pass_cnt++;
    endtask

    task automatic test_mem();
        do_single("lw1_007b", 1'b1, 8'hA1, 16'h0, 16'h0, 16'h007B, 4'h3, 1'b1, 1'b0);
        do_single("sw_000d", 1'b1, 8'hC2, 16'h1234, 16'h0003, 16'h000A, 4'h0, 1'b0, 1'b1);
        total_cnt++;
        if (addr_out !== 16'h000D || store_data_out !== 16'h1234 || set_memwrite_out !== 1'b1)
            $display("FAIL sw_literal: addr=%h store=%h mw=%b, want 000d 1234 1",
                     addr_out, store_data_out, set_memwrite_out);
        else pass_cnt++;
        do_single("lw_imm_plus_b", 1'b1, 8'hC1, 16'h0, 16'hFFF0, 16'h0020, 4'h7, 1'b1, 1'b0);
    endtask

    task automatic test_cmp_flags();
        do_single("cmp_lt", 1'b1, 8'h49, 16'h0003, 16'h0009, 16'h0, 4'h1, 1'b0, 1'b0);
        total_cnt++;
        if (result_out !== 16'hFFFF || flags_out !== 2'b10)
            $display("FAIL cmp_literal: result=%h flags=%b, want ffff 10", result_out, flags_out);
        else pass_cnt++;
        do_single("add_keeps_flags", 1'b1, 8'h43, 16'h0001, 16'h0001, 16'h0, 4'h1, 1'b1, 1'b0);
        do_single("cmp_eq", 1'b1, 8'h49, 16'h4242, 16'h4242, 16'h0, 4'h1, 1'b0, 1'b0);
        do_single("cmp_gt", 1'b1, 8'h49, 16'h9000, 16'h0001, 16'h0, 4'h1, 1'b0, 1'b0);
        do_single("nop_bubble", 1'b1, 8'h0F, 16'h1234, 16'h5678, 16'h0, 4'h9, 1'b1, 1'b1);
        do_single("invalid_in", 1'b0, 8'h43, 16'h1234, 16'h5678, 16'h0, 4'h9, 1'b1, 1'b1);
    endtask

    task automatic test_random_single();
        logic [7:0] ops [11] = '{8'hC1, 8'hA1, 8'hC2, 8'h43, 8'h44, 8'h47,
                                 8'h48, 8'h49, 8'h2A, 8'h0F, 8'h00};
        for (int i = 0; i < 60; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = (i % 7 == 0) ? a : 16'($urandom);
            do_single("random_single", ($urandom_range(0, 7) != 0),
                      ops[$urandom_range(0, 10)], a, b, 16'($urandom),
                      4'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_mul();
        run_mc("mul_0101_0102", 8'h45, 16'h0101, 16'h0102, 4'h4, 1'b1);
        apply(1'b0, 8'h0F, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
        step();
        total_cnt++;
        if (valid_out !== 1'b0)
            $display("FAIL mul_valid_one_cycle: valid=%b, want 0", valid_out);
        else pass_cnt++;
        for (int i = 0; i < 4; i++)
            run_mc("mul_random", 8'h45, 16'($urandom), 16'($urandom), 4'($urandom), 1'b1);
        run_mc("mul_ffff_ffff", 8'h45, 16'hFFFF, 16'hFFFF, 4'hF, 1'b1);
    endtask

    // Each run_mc presents its op right after the previous completion edge, so
    // a late acceptance would fail the accept check.
    task automatic test_back_to_back();
        run_mc("div_0064_0007", 8'h46, 16'h0064, 16'h0007, 4'h5, 1'b1);
        run_mc("div_by_zero", 8'h46, 16'h1234, 16'h0000, 4'h6, 1'b1);
        run_mc("div_big_small", 8'h46, 16'hFFFF, 16'h0001, 4'h7, 1'b1);
        run_mc("div_small_big", 8'h46, 16'h0003, 16'h8000, 4'h8, 1'b0);
        for (int i = 0; i < 4; i++)
            run_mc("div_random", 8'h46, 16'($urandom), 16'($urandom_range(1, 300)), 4'($urandom), 1'b1);
        do_single("single_after_div", 1'b1, 8'h44, 16'h0010, 16'h0011, 16'h0, 4'h2, 1'b1, 1'b0);
    endtask

    task automatic test_reset_busy();
        apply(1'b1, 8'h45, 16'h00FF, 16'h00FF, 16'h0, 4'hA, 1'b1, 1'b0);
        step();
        for (int k = 1; k <= 7; k++) step();
        reset = 1'b0;
        apply(1'b1, 8'h43, 16'h0001, 16'h0002, 16'h0, 4'h3, 1'b1, 1'b0);
        step();
        flags_m = 2'b00;
        total_cnt++;
        if (get_obs() !== out_t'('0) || stall_out !== 1'b0)
            $display("FAIL reset_in_busy: got %h stall=%b, want 0 stall=0", get_obs(), stall_out);
        else pass_cnt++;
        reset = 1'b1;
        do_single("add_after_abort", 1'b1, 8'h43, 16'h0001, 16'h0002, 16'h0, 4'h3, 1'b1, 1'b0);
        do_single("idle_after_abort", 1'b0, 8'h43, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        flags_m = 2'b00;
        apply(1'b0, 8'h0F, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);
        test_reset();
        test_add();
        test_mem();
        test_cmp_flags();
        test_random_single();
        test_mul();
        test_back_to_back();
        test_reset_busy();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
